nibble_bus_responder: RTL and testbench
=======================================

Name: nibble_bus_responder

Overview:
Far-end responder for the 4-bit serialized core memory bus. Per transaction it:
- accepts request beats (nibble, nibble strobe, write flag, address);
- reassembles 32-bit write data and byte enables, then issues one word-wide request to a simple req/gnt/rvalid memory port;
- serializes 32-bit read data back as 8 LSB-first nibbles under valid/ready.

It sits on the memory/companion side of the pad interface, opposite the core-side serializer.

Parameters:
ADDR_W, 8, width of request address beat and memory address (passed through unmodified)
BEATS, 8, nibbles per 32-bit word (fixed; other values unsupported)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_nibble_i  input  4  request data nibble
req_strb_i  input  1  nibble strobe (write beats only)
req_write_i  input  1  1=write, 0=read; sampled on first beat only
req_addr_i  input  ADDR_W  word address; sampled on first beat only
req_valid_i  input  1  request beat valid
req_ready_o  output  1  request beat ready
rsp_nibble_o  output  4  response nibble
rsp_valid_o  output  1  response beat valid
rsp_ready_i  input  1  response beat ready
mem_req_o  output  1  memory request
mem_gnt_i  input  1  memory grant
mem_addr_o  output  ADDR_W  latched address
mem_we_o  output  1  write enable
mem_be_o  output  4  byte enables
mem_wdata_o  output  32  assembled write data
mem_rvalid_i  input  1  read data valid
mem_rdata_i  input  32  read data
proto_err_o  output  1  one-cycle pulse on strobe mismatch

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, all outputs 0 (req_ready_o=0 while rst asserted), data/strobe/address registers 0, beat counter 0.
- Beat transfer: a beat transfers when valid&&ready on the same rising edge. Both sides may hold valid indefinitely; data must stay stable while valid&&!ready.
- States: IDLE, COLLECT, MEM_REQ, MEM_WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On a beat: latch addr and write flag.
  - Write beat: store nibble into data[3:0] and strobe into strb[0]; cnt=1; -> COLLECT.
  - Read beat: nibble and strobe ignored; -> MEM_REQ.
- COLLECT:
  - req_ready_o=1.
  - Each beat stores nibble at data[4*cnt+3:4*cnt] and strobe at strb[cnt]; cnt++.
  - Beat with cnt==7 -> MEM_REQ; cnt=0.
  - req_write_i/req_addr_i ignored in this state.
- Byte enables: mem_be_o[k] = strb[2k] & strb[2k+1].
  - If strb[2k] != strb[2k+1] for any k, proto_err_o pulses 1 for exactly the cycle of entry into MEM_REQ; the write still proceeds with the AND rule.
- MEM_REQ:
  - req_ready_o=0; mem_req_o=1; addr/we/be/wdata held stable until mem_gnt_i.
  - For reads: mem_we_o=0, mem_be_o=4'hF.
  - On gnt, write: -> IDLE (no response, unless the optional feature is enabled).
  - On gnt, read: -> MEM_WAIT; if mem_rvalid_i is high in the same cycle, latch rdata and go directly to RESP.
- MEM_WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i: latch mem_rdata_i into shift reg; cnt=0; -> RESP.
- RESP:
  - rsp_valid_o=1; rsp_nibble_o=shift[3:0].
  - On rsp_ready_i: shift right 4; cnt++. Beat with cnt==7 -> IDLE; rsp_valid_o drops the next cycle.
- Latency: the first read response nibble is valid 1 cycle after the mem_rvalid_i edge. Write commit: mem_req_o rises 1 cycle after the 8th request beat.
- Pipelining: no overlap. A new request is not accepted until the state returns to IDLE, so back-to-back transactions cost at least 1 IDLE cycle.
- Reset mid-transaction: immediately abandons it. Partial write data is discarded, never committed; mem_req_o and rsp_valid_o drop asynchronously.
- Out-of-state inputs: mem_rvalid_i outside MEM_REQ/MEM_WAIT and mem_gnt_i outside MEM_REQ are ignored.

Optional Feature:
NIBBLE_RSP_WRITE_ACK_EN:
- Defined: after a write grant, enter RESP for a single beat with rsp_nibble_o=4'h0, then return to IDLE when rsp_ready_i is seen.
- Undefined: writes return to IDLE directly on grant and produce no response beat.

Test Plan:
- Write: addr=8'h5A, nibbles of 32'hDEADBEEF LSB-first, all strb=1, ready immediately -> mem_req_o rises 1 cycle after beat 8; mem_addr_o=5A, mem_we_o=1, mem_be_o=F, mem_wdata_o=DEADBEEF; no response beat (macro off).
- Partial write: strb pattern 1,1,0,0,0,0,1,1 -> mem_be_o=4'b1001, proto_err_o=0. Pattern 1,0,... -> be[0]=0, proto_err_o pulses once.
- Read: addr=8'h03; mem_gnt_i after 2 cycles; mem_rvalid_i 3 cycles later with 32'h12345678 -> rsp_nibble_o sequence 8,7,6,5,4,3,2,1. With rsp_ready_i toggling 1/0, each nibble holds while stalled.
- Same-cycle gnt+rvalid with rdata=32'hA5A5A5A5 -> RESP entered directly, MEM_WAIT skipped; nibbles 5,A,5,A,5,A,5,A.
- Reset after 4 write beats, then a full read -> no memory write issued; read completes normally; req_ready_o=0 during reset.
- With NIBBLE_RSP_WRITE_ACK_EN defined: a write yields exactly one response beat 4'h0 after grant; req_ready_o stays 0 until that beat is accepted.

Source files
------------

// File: rtl/nibble_bus_responder_if.sv
// Bundle of the serialized request/response bus and the word-wide memory
// port seen by nibble_bus_responder. The slave modport is the responder's
// view; the master modport is the far side (pads + memory).
interface nibble_bus_responder_if #(
  parameter int ADDR_W = 8
);
  logic [3:0]        req_nibble_i;
  logic              req_strb_i;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [3:0]        rsp_nibble_o;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;
  logic              proto_err_o;

  modport slave (
    input  req_nibble_i, req_strb_i, req_write_i, req_addr_i, req_valid_i,
    output req_ready_o,
    output rsp_nibble_o, rsp_valid_o,
    input  rsp_ready_i,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output proto_err_o
  );

  modport master (
    output req_nibble_i, req_strb_i, req_write_i, req_addr_i, req_valid_i,
    input  req_ready_o,
    input  rsp_nibble_o, rsp_valid_o,
    output rsp_ready_i,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  proto_err_o
  );
endinterface

// File: rtl/nibble_bus_responder.sv
// Far-end responder of the 4-bit serialized memory bus: collects request
// nibbles into a 32-bit word with byte enables, issues one req/gnt/rvalid
// memory access, and streams read data back as 8 LSB-first nibbles.
// Optional feature macro: NIBBLE_RSP_WRITE_ACK_EN (one 4'h0 response beat
// acknowledges every granted write).
module nibble_bus_responder #(
  parameter int ADDR_W = 8,
  parameter int BEATS  = 8
) (
  input logic                    clk,
  input logic                    rst,
  nibble_bus_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  // A byte is enabled only when both of its nibble strobes are set.
  function automatic logic [3:0] be_from_strb(input logic [7:0] s);
    logic [3:0] be;
    for (int k = 0; k < 4; k++) begin
      be[k] = s[2*k] & s[2*k+1];
    end
    return be;
  endfunction

  // Any byte whose two nibble strobes disagree is a protocol error.
  function automatic logic strb_mismatch(input logic [7:0] s);
    logic m;
    m = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m = m | (s[2*k] ^ s[2*k+1]);
    end
    return m;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       data_q, data_d;
  logic [7:0]        strb_q, strb_d;
  logic [31:0]       shift_q, shift_d;
  logic [3:0]        be_q, be_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              mem_req_q, mem_req_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              req_beat_s;

  assign req_beat_s = bus.req_valid_i & ready_q;

  // Next-state and datapath updates for the request/memory/response sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    data_d  = data_q;
    strb_d  = strb_q;
    shift_d = shift_q;
    be_d    = be_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_beat_s) begin
          addr_d = bus.req_addr_i;
          we_d   = bus.req_write_i;
          if (bus.req_write_i) begin
            data_d[3:0] = bus.req_nibble_i;
            strb_d[0]   = bus.req_strb_i;
            cnt_d       = 3'd1;
            state_d     = COLLECT;
          end else begin
            cnt_d   = 3'd0;
            be_d    = 4'hF;
            state_d = MEM_REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (req_beat_s) begin
          data_d[4*cnt_q +: 4] = bus.req_nibble_i;
          strb_d[cnt_q]        = bus.req_strb_i;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = 3'd0;
            be_d    = be_from_strb(strb_d);
            err_d   = strb_mismatch(strb_d);
            state_d = MEM_REQ;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      MEM_REQ: begin
        if (bus.mem_gnt_i) begin
          if (we_q) begin
`ifdef NIBBLE_RSP_WRITE_ACK_EN
            // Single zero beat: start the counter at the last beat.
            shift_d = 32'h0000_0000;
            cnt_d   = LAST_BEAT;
            state_d = RESP;
`else
            state_d = IDLE;
`endif
          end else if (bus.mem_rvalid_i) begin
            shift_d = bus.mem_rdata_i;
            cnt_d   = 3'd0;
            state_d = RESP;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          state_d = MEM_REQ;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_rvalid_i) begin
          shift_d = bus.mem_rdata_i;
          cnt_d   = 3'd0;
          state_d = RESP;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          shift_d = {4'h0, shift_q[31:4]};
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = 3'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake outputs are registered copies of the next state's decode.
    ready_d     = (state_d == IDLE) || (state_d == COLLECT);
    mem_req_d   = (state_d == MEM_REQ);
    rsp_valid_d = (state_d == RESP);
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      data_q      <= 32'h0000_0000;
      strb_q      <= 8'h00;
      shift_q     <= 32'h0000_0000;
      be_q        <= 4'h0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      shift_q     <= shift_d;
      be_q        <= be_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready_o  = ready_q;
  assign bus.rsp_nibble_o = shift_q[3:0];
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_be_o     = be_q;
  assign bus.mem_wdata_o  = data_q;
  assign bus.proto_err_o  = err_q;

endmodule

// File: tb/tb_nibble_bus_responder.sv
// Self-checking bench for nibble_bus_responder: table of transactions plus a
// hand-written reset-abort sequence; memory requests and response nibbles are
// predicted into queues when stimulus is driven and popped when they appear.
module tb_nibble_bus_responder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nibble_bus_responder_if #(.ADDR_W(8)) bus ();

  nibble_bus_responder #(.ADDR_W(8), .BEATS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;     // write data, or read data returned by memory
    logic [7:0]  strb;     // strb[i] goes with beat i
    int          gd;       // cycles from mem_req rise to grant (>=1)
    int          rd;       // cycles from grant to rvalid (0 = same cycle)
    logic        toggle;   // rsp_ready alternates 1/0
    logic [3:0]  exp_be;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  vec_t     vecs[6];
  mem_exp_t mem_q[$];
  logic [3:0] rsp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [3:0] nib, input logic s, input logic wr, input logic [7:0] a);
    int n;
    n = 0;
    bus.req_nibble_i = nib;
    bus.req_strb_i   = s;
    bus.req_write_i  = wr;
    bus.req_addr_i   = a;
    bus.req_valid_i  = 1'b1;
    @(negedge clk);
    while (!bus.req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready", {31'd0, bus.req_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic mem_serve(input int gd, input int rd, input logic [31:0] rdata, input logic wr);
    mem_exp_t e;
    repeat (gd) begin
      @(posedge clk);
      #1;
    end
    bus.mem_gnt_i = 1'b1;
    if (!wr && rd == 0) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = rdata;
    end
    @(negedge clk);
    check("mem_req_at_gnt", {31'd0, bus.mem_req_o}, 32'd1);
    if (mem_q.size() == 0) begin
      check("mem_unexpected", 32'd1, {31'd0, 1'b0});
    end else begin
      e = mem_q.pop_front();
      check("mem_addr", {24'd0, bus.mem_addr_o}, {24'd0, e.addr});
      check("mem_we", {31'd0, bus.mem_we_o}, {31'd0, e.we});
      check("mem_be", {28'd0, bus.mem_be_o}, {28'd0, e.be});
      if (e.we) check("mem_wdata", bus.mem_wdata_o, e.wdata);
    end
    @(posedge clk);
    #1;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    if (!wr && rd > 0) begin
      check("mem_wait_req_low", {31'd0, bus.mem_req_o}, 32'd0);
      check("mem_wait_no_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
      repeat (rd - 1) begin
        @(posedge clk);
        #1;
      end
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = rdata;
      @(posedge clk);
      #1;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = 32'h0BAD_0BAD;
    end
    if (!wr) check("rsp_latency", {31'd0, bus.rsp_valid_o}, 32'd1);
  endtask

  task automatic drain(input logic toggle);
    int n;
    logic t;
    logic [3:0] e;
    n = 0;
    t = 1'b1;
    while (rsp_q.size() != 0 && n < 200) begin
      bus.rsp_ready_i = t;
      @(negedge clk);
      if (bus.rsp_valid_o && t) begin
        e = rsp_q.pop_front();
        check("rsp_nibble", {28'd0, bus.rsp_nibble_o}, {28'd0, e});
      end
      @(posedge clk);
      #1;
      if (toggle) t = ~t;
      n++;
    end
    bus.rsp_ready_i = 1'b0;
    check("rsp_drained", rsp_q.size(), 32'd0);
    rsp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    mem_exp_t e;
    e.addr  = v.addr;
    e.we    = v.wr;
    e.be    = v.wr ? v.exp_be : 4'hF;
    e.wdata = v.data;
    mem_q.push_back(e);
    if (v.wr) begin
      for (int i = 0; i < 8; i++) send_beat(v.data[4*i +: 4], v.strb[i], 1'b1, v.addr);
    end else begin
      for (int i = 0; i < 8; i++) rsp_q.push_back(v.data[4*i +: 4]);
      send_beat(4'h0, 1'b0, 1'b0, v.addr);
    end
    check("commit_latency", {31'd0, bus.mem_req_o}, 32'd1);
    check("proto_err_pulse", {31'd0, bus.proto_err_o}, {31'd0, v.exp_err});
    check("ready_low_in_req", {31'd0, bus.req_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    check("proto_err_drop", {31'd0, bus.proto_err_o}, 32'd0);
    mem_serve(v.gd - 1, v.rd, v.data, v.wr);
    if (v.wr) begin
`ifdef NIBBLE_RSP_WRITE_ACK_EN
      check("ack_ready_low", {31'd0, bus.req_ready_o}, 32'd0);
      rsp_q.push_back(4'h0);
      drain(1'b0);
`else
      check("no_write_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
`endif
    end else begin
      drain(v.toggle);
    end
    check("idle_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("idle_no_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
  endtask

  initial begin
    vec_t rv;
    checks   = 0;
    failures = 0;
    //              wr    addr   data          strb          gd rd tog   be       err
    vecs[0] = '{1'b1, 8'h5A, 32'hDEADBEEF, 8'b1111_1111, 1, 0, 1'b0, 4'b1111, 1'b0};
    vecs[1] = '{1'b1, 8'h11, 32'h0F0F1234, 8'b1100_0011, 2, 0, 1'b0, 4'b1001, 1'b0};
    vecs[2] = '{1'b1, 8'h22, 32'hCAFEF00D, 8'b1111_1101, 3, 0, 1'b0, 4'b1110, 1'b1};
    vecs[3] = '{1'b0, 8'h03, 32'h12345678, 8'b0000_0000, 2, 3, 1'b1, 4'b1111, 1'b0};
    vecs[4] = '{1'b0, 8'h44, 32'hA5A5A5A5, 8'b0000_0000, 1, 0, 1'b0, 4'b1111, 1'b0};
    vecs[5] = '{1'b0, 8'h7F, 32'hFFFF0000, 8'b0000_0000, 1, 1, 1'b1, 4'b1111, 1'b0};

    bus.req_nibble_i = 4'h0;
    bus.req_strb_i   = 1'b0;
    bus.req_write_i  = 1'b0;
    bus.req_addr_i   = 8'h00;
    bus.req_valid_i  = 1'b0;
    bus.rsp_ready_i  = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0000_0000;
    rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, bus.req_ready_o}, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("rst_proto_err", {31'd0, bus.proto_err_o}, 32'd0);
    check("rst_wdata", bus.mem_wdata_o, 32'd0);
    check("rst_be", {28'd0, bus.mem_be_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, bus.req_ready_o}, 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset after four write beats: nothing may be committed.
    for (int i = 0; i < 4; i++) send_beat(4'h9, 1'b1, 1'b1, 8'h66);
    rst = 1'b1;
    #1;
    check("abort_ready_low", {31'd0, bus.req_ready_o}, 32'd0);
    check("abort_no_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_still_no_req", {31'd0, bus.mem_req_o}, 32'd0);
    rv = '{1'b0, 8'h3C, 32'h89ABCDEF, 8'b0000_0000, 2, 2, 1'b0, 4'b1111, 1'b0};
    run_vec(rv);
    check("mem_q_empty", mem_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
